fwd_ctrl: RTL and testbench
===========================

# fwd_ctrl

Forwarding and hazard controller that drives the EX-stage operand-select inputs (`forward_rs`/`forward_rs_data`, `forward_rt`/`forward_rt_data`) consumed by the ALU source mux. It keeps a shadow MEM/WB tag-and-data pipeline of in-flight register writes. For the instruction in ID it computes registered forwarding decisions that are presented when that instruction enters EX. It also generates the load-use stall and the multiply/divide busy stall.

## Interface
Parameters:
- `DIV_CYCLES`, 32: EX-stage divider latency in cycles; HI/LO readers stall until it completes.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `freeze` in 1: global pipeline hold (cache miss); all state holds, no outputs change.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt` in 5: ID source register indices.
- `id_rs_used`, `id_rt_used` in 1: ID instruction reads rs / rt.
- `id_hilo_used` in 1: ID instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
- `ex_valid`, `ex_wen` in 1: EX instruction is real / writes a GPR.
- `ex_wreg` in 5: EX destination register.
- `ex_is_load` in 1: EX instruction is a load.
- `ex_div_start` in 1: EX instruction is div/divu, sampled once per instruction.
- `ex_result` in `W_DATA: EX result this cycle.
- `mem_load_data` in `W_DATA: load data valid during MEM.
- `forward_rs`, `forward_rt` out 1: registered; EX uses forwarded data.
- `forward_rs_data`, `forward_rt_data` out `W_DATA: registered forwarded values.
- `stall_id` out 1: combinational; hold PC and IF/ID.
- `bubble_ex` out 1: combinational; load a NOP into ID/EX.

## Operation
- Shadow slots `mem_s`, `wb_s` each hold {valid, wreg, is_load, data}. Each non-frozen edge: `mem_s` ← EX {ex_valid&ex_wen, ex_wreg, ex_is_load, ex_result}. `wb_s` ← `mem_s`, with data replaced by `mem_load_data` when `mem_s.is_load`.
- Match for source X (rs or rt): `id_X_used` and X ≠ 0 and producer valid and producer wreg = X. Register 0 is never forwarded.
- Priority is youngest first: EX (`ex_result`), then `mem_s` (`mem_load_data` if load, else `mem_s.data`), then `wb_s.data`. No match → forward = 0, data = 0.
- Load-use: EX match with `ex_is_load`=1 → `stall_id`=`bubble_ex`=1. On that edge the forward registers load 0. The next cycle the load is in `mem_s` and resolves through the MEM path.
- Divider: `ex_div_start`=1 on a non-frozen edge loads `div_cnt` with DIV_CYCLES-1. It decrements each non-frozen edge down to 0. busy = `div_cnt` ≠ 0. `id_valid`&`id_hilo_used`&busy → stall_id=bubble_ex=1.
- stall_id = bubble_ex = id_valid & (load_use | hilo_busy), and both are 0 while `freeze`=1.
- When `id_valid`=0: forward registers load 0 and no stall is raised.

## Timing
- Reset: forward_rs = forward_rt = 0; data outputs = 0; slots invalid; div_cnt = 0; stall_id = bubble_ex = 0.
- Forward outputs have one-cycle latency: computed in ID, valid for the whole EX cycle.
- A load is followed by exactly one stall cycle; a div causes at most DIV_CYCLES-1 stall cycles.
- Simultaneous load-use and hilo_busy produce a single combined stall. `ex_div_start` during an active count restarts the count.
- Under `freeze`, `mem_load_data` is sampled only on the unfreezing edge.
- Reset asserted mid-stall or mid-divide clears everything on assertion; the pipeline restarts clean.

## Structure
- Shared package: slot struct type, `REG_ZERO`, `DIV_CYCLES` default, and the `W_DATA`/5-bit register index widths.
- One sub-module `fwd_match`: combinational priority selector (three producers → forward/data) instantiated once each for rs and rt.

## Test plan
- EX `addu $3` (result 0x11), ID `sub` reads `$3` as rs → next cycle forward_rs=1, forward_rs_data=0x11, stall_id=0.
- EX `lw $5`, ID reads `$5` as rt → stall_id=bubble_ex=1 for 1 cycle. Next cycle mem_load_data=0xDEADBEEF → following cycle forward_rt=1, data=0xDEADBEEF.
- EX writes `$7`=0xA, `mem_s` also `$7`=0xB, ID reads `$7` → forward data 0xA; an ID read of `$0` while EX writes `$0` → forward=0.
- `div` enters EX, `mfhi` in ID next cycle → stall_id high for exactly 31 cycles (DIV_CYCLES=32), then released.
- Load-use stall with `freeze` held 3 cycles → stall_id=0 and outputs frozen during freeze; the stall resolves after release with correct load data.
- Assert `rst` mid-divide (div_cnt=10) → immediately all outputs 0; mfhi in ID after release sees no stall.

Source files
------------

// File: rtl/fwd_ctrl_pkg.sv
// Shared types and constants for the forwarding/hazard controller.
// Holds the shadow write-slot struct, register/data widths and the divider default.
// Imported by fwd_ctrl and fwd_match.
package fwd_ctrl_pkg;

  localparam int W_DATA         = 32;
  localparam int W_REG          = 5;
  localparam int DIV_CYCLES_DEF = 32;

  localparam logic [W_REG-1:0] REG_ZERO = '0;

  // One in-flight GPR write as seen by the forwarding network.
  typedef struct packed {
    logic              valid;
    logic [W_REG-1:0]  wreg;
    logic              is_load;
    logic [W_DATA-1:0] data;
  } slot_t;

endpackage

// File: rtl/fwd_match.sv
// Combinational youngest-first forwarding selector for one source operand.
// Ports: used/src describe the ID read; ex_*, mem_*, wb_* describe the three
// producers (mem_data already resolved for loads); hit/data are the decision, ex_hit flags an EX match.
module fwd_match
  import fwd_ctrl_pkg::*;
(
  input  logic              used,
  input  logic [W_REG-1:0]  src,
  input  logic              ex_valid,
  input  logic [W_REG-1:0]  ex_wreg,
  input  logic [W_DATA-1:0] ex_data,
  input  logic              mem_valid,
  input  logic [W_REG-1:0]  mem_wreg,
  input  logic [W_DATA-1:0] mem_data,
  input  logic              wb_valid,
  input  logic [W_REG-1:0]  wb_wreg,
  input  logic [W_DATA-1:0] wb_data,
  output logic              hit,
  output logic [W_DATA-1:0] data,
  output logic              ex_hit
);

  logic reads;
  logic mem_hit;
  logic wb_hit;

  // $0 is hardwired, so a read of it never takes a forwarded value.
  assign reads   = used && (src != REG_ZERO);
  assign ex_hit  = reads && ex_valid  && (ex_wreg  == src);
  assign mem_hit = reads && mem_valid && (mem_wreg == src);
  assign wb_hit  = reads && wb_valid  && (wb_wreg  == src);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (ex_hit) begin
      hit  = 1'b1;
      data = ex_data;
    end else if (mem_hit) begin
      hit  = 1'b1;
      data = mem_data;
    end else if (wb_hit) begin
      hit  = 1'b1;
      data = wb_data;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// EX-stage forwarding and hazard controller: shadow MEM/WB write slots, registered
// forward decisions for the instruction leaving ID, load-use and HI/LO-busy stalls.
// Ports: clk/rst/freeze; ID read info; EX write/div info; mem_load_data; forward_* (registered); stall_id/bubble_ex (comb).
module fwd_ctrl
  import fwd_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              id_valid,
  input  logic [W_REG-1:0]  id_rs,
  input  logic [W_REG-1:0]  id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_hilo_used,
  input  logic              ex_valid,
  input  logic              ex_wen,
  input  logic [W_REG-1:0]  ex_wreg,
  input  logic              ex_is_load,
  input  logic              ex_div_start,
  input  logic [W_DATA-1:0] ex_result,
  input  logic [W_DATA-1:0] mem_load_data,
  output logic              forward_rs,
  output logic [W_DATA-1:0] forward_rs_data,
  output logic              forward_rt,
  output logic [W_DATA-1:0] forward_rt_data,
  output logic              stall_id,
  output logic              bubble_ex
);

  localparam int W_CNT = $clog2(DIV_CYCLES + 1);

  slot_t             mem_s;
  // The WB slot never needs is_load: load data is already resolved on entry.
  logic              wb_valid;
  logic [W_REG-1:0]  wb_wreg;
  logic [W_DATA-1:0] wb_data;
  logic [W_CNT-1:0]  div_cnt;

  logic              ex_writes;
  logic [W_DATA-1:0] mem_data;
  logic              rs_hit, rt_hit, rs_ex_hit, rt_ex_hit;
  logic [W_DATA-1:0] rs_data, rt_data;
  logic              load_use, hilo_busy, stall;

  assign ex_writes = ex_valid & ex_wen;
  assign mem_data  = mem_s.is_load ? mem_load_data : mem_s.data;

  fwd_match u_match_rs (
    .used      (id_rs_used),
    .src       (id_rs),
    .ex_valid  (ex_writes),
    .ex_wreg   (ex_wreg),
    .ex_data   (ex_result),
    .mem_valid (mem_s.valid),
    .mem_wreg  (mem_s.wreg),
    .mem_data  (mem_data),
    .wb_valid  (wb_valid),
    .wb_wreg   (wb_wreg),
    .wb_data   (wb_data),
    .hit       (rs_hit),
    .data      (rs_data),
    .ex_hit    (rs_ex_hit)
  );

  fwd_match u_match_rt (
    .used      (id_rt_used),
    .src       (id_rt),
    .ex_valid  (ex_writes),
    .ex_wreg   (ex_wreg),
    .ex_data   (ex_result),
    .mem_valid (mem_s.valid),
    .mem_wreg  (mem_s.wreg),
    .mem_data  (mem_data),
    .wb_valid  (wb_valid),
    .wb_wreg   (wb_wreg),
    .wb_data   (wb_data),
    .hit       (rt_hit),
    .data      (rt_data),
    .ex_hit    (rt_ex_hit)
  );

  // An EX load's data does not exist yet, so an EX match on a load must wait a cycle.
  assign load_use  = (rs_ex_hit | rt_ex_hit) & ex_is_load;
  assign hilo_busy = id_hilo_used & (div_cnt != '0);
  assign stall     = ~freeze & id_valid & (load_use | hilo_busy);
  assign stall_id  = stall;
  assign bubble_ex = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_s    <= '0;
      wb_valid <= 1'b0;
      wb_wreg  <= '0;
      wb_data  <= '0;
    end else if (!freeze) begin
      mem_s.valid   <= ex_writes;
      mem_s.wreg    <= ex_wreg;
      mem_s.is_load <= ex_is_load;
      mem_s.data    <= ex_result;
      wb_valid      <= mem_s.valid;
      wb_wreg       <= mem_s.wreg;
      wb_data       <= mem_data;
    end
  end

  // A new div restarts the count even if one is already running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!freeze) begin
      if (ex_div_start)
        div_cnt <= W_CNT'(DIV_CYCLES - 1);
      else if (div_cnt != '0)
        div_cnt <= div_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      forward_rs      <= 1'b0;
      forward_rs_data <= '0;
      forward_rt      <= 1'b0;
      forward_rt_data <= '0;
    end else if (!freeze) begin
      if (!id_valid || load_use) begin
        forward_rs      <= 1'b0;
        forward_rs_data <= '0;
        forward_rt      <= 1'b0;
        forward_rt_data <= '0;
      end else begin
        forward_rs      <= rs_hit;
        forward_rs_data <= rs_data;
        forward_rt      <= rt_hit;
        forward_rt_data <= rt_data;
      end
    end
  end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: directed vector table, hand-written
// multi-cycle sequences (divide, freeze, reset mid-divide) and a randomized run
// against a queue-based model of the in-flight GPR writes.
module tb_fwd_ctrl;
  import fwd_ctrl_pkg::*;

  localparam int DIVC = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0;
  logic        id_rs_used = 1'b0, id_rt_used = 1'b0, id_hilo_used = 1'b0;
  logic        ex_valid = 1'b0, ex_wen = 1'b0;
  logic [4:0]  ex_wreg = '0;
  logic        ex_is_load = 1'b0, ex_div_start = 1'b0;
  logic [31:0] ex_result = '0, mem_load_data = '0;
  logic        forward_rs, forward_rt, stall_id, bubble_ex;
  logic [31:0] forward_rs_data, forward_rt_data;

  fwd_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rs_used      (id_rs_used),
    .id_rt_used      (id_rt_used),
    .id_hilo_used    (id_hilo_used),
    .ex_valid        (ex_valid),
    .ex_wen          (ex_wen),
    .ex_wreg         (ex_wreg),
    .ex_is_load      (ex_is_load),
    .ex_div_start    (ex_div_start),
    .ex_result       (ex_result),
    .mem_load_data   (mem_load_data),
    .forward_rs      (forward_rs),
    .forward_rs_data (forward_rs_data),
    .forward_rt      (forward_rt),
    .forward_rt_data (forward_rt_data),
    .stall_id        (stall_id),
    .bubble_ex       (bubble_ex)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu, input logic hilo);
    id_valid = v; id_rs = rs; id_rt = rt;
    id_rs_used = rsu; id_rt_used = rtu; id_hilo_used = hilo;
  endtask

  task automatic set_ex(input logic v, input logic w, input logic [4:0] r,
                        input logic ld, input logic [31:0] res, input logic dv);
    ex_valid = v; ex_wen = w; ex_wreg = r; ex_is_load = ld; ex_result = res; ex_div_start = dv;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    set_ex(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
    freeze = 1'b0;
    mem_load_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        idv;
    logic [4:0]  rs, rt;
    logic        rsu, rtu;
    logic        exv, exw;
    logic [4:0]  exr;
    logic        exl;
    logic [31:0] res, mld;
    logic        stall, frs;
    logic [31:0] frsd;
    logic        frt;
    logic [31:0] frtd;
  } vec_t;

  function automatic vec_t mk(
      input logic idv, input logic [4:0] rs, input logic [4:0] rt, input logic rsu, input logic rtu,
      input logic exv, input logic exw, input logic [4:0] exr, input logic exl,
      input logic [31:0] res, input logic [31:0] mld,
      input logic stall, input logic frs, input logic [31:0] frsd, input logic frt, input logic [31:0] frtd);
    vec_t v;
    v.idv = idv; v.rs = rs; v.rt = rt; v.rsu = rsu; v.rtu = rtu;
    v.exv = exv; v.exw = exw; v.exr = exr; v.exl = exl; v.res = res; v.mld = mld;
    v.stall = stall; v.frs = frs; v.frsd = frsd; v.frt = frt; v.frtd = frtd;
    return v;
  endfunction

  vec_t tbl[10];

  // ---------------- reference model ----------------
  typedef struct {
    bit        v;
    bit [4:0]  r;
    bit        ld;   // data still to come from the memory stage
    bit [31:0] d;
  } wr_t;

  wr_t inflight[$];   // youngest first: [0] is in MEM, [1] in WB
  int  nf_edges;
  int  div_mark;

  function automatic void lookup(input bit used, input bit [4:0] src,
                                 output bit hit, output bit [31:0] d, output bit ex_load);
    hit = 0; d = 0; ex_load = 0;
    if (!used || src == 5'd0) return;
    if (ex_valid && ex_wen && ex_wreg == src) begin
      hit = 1; d = ex_result; ex_load = ex_is_load;
      return;
    end
    foreach (inflight[i]) begin
      if (inflight[i].v && inflight[i].r == src) begin
        hit = 1;
        d = inflight[i].ld ? mem_load_data : inflight[i].d;
        return;
      end
    end
  endfunction

  task automatic model_edge();
    wr_t t;
    nf_edges++;
    if (ex_div_start) div_mark = nf_edges;
    if (inflight.size() > 0 && inflight[0].ld) begin
      t = inflight.pop_front();
      t.d = mem_load_data;
      t.ld = 0;
      inflight.push_front(t);
    end
    t.v = ex_valid && ex_wen; t.r = ex_wreg; t.ld = ex_is_load; t.d = ex_result;
    inflight.push_front(t);
    if (inflight.size() > 2) void'(inflight.pop_back());
  endtask

  initial begin
    int scount;
    bit hs, ht, ls, lt, busy, e_stall;
    bit [31:0] ds, dt;
    bit e_frs, e_frt;
    bit [31:0] e_frsd, e_frtd;

    // idv rs rt rsu rtu | exv exw exr exl res mld | stall frs frsd frt frtd
    tbl[0] = mk(1, 3, 0, 1, 0, 1, 1, 3, 0, 32'h11, 32'h0,        0, 1, 32'h11, 0, 32'h0);
    tbl[1] = mk(1, 3, 4, 1, 1, 1, 1, 7, 0, 32'hB,  32'h0,        0, 1, 32'h11, 0, 32'h0);
    tbl[2] = mk(1, 7, 3, 1, 1, 1, 1, 7, 0, 32'hA,  32'h0,        0, 1, 32'hA,  1, 32'h11);
    tbl[3] = mk(1, 0, 7, 1, 1, 1, 1, 0, 0, 32'h55, 32'h0,        0, 0, 32'h0,  1, 32'hA);
    tbl[4] = mk(1, 7, 5, 1, 1, 1, 1, 5, 1, 32'h99, 32'h1234,     1, 0, 32'h0,  0, 32'h0);
    tbl[5] = mk(1, 7, 5, 1, 1, 0, 0, 0, 0, 32'h0,  32'hDEADBEEF, 0, 0, 32'h0,  1, 32'hDEADBEEF);
    tbl[6] = mk(1, 5, 5, 1, 1, 0, 0, 0, 0, 32'h0,  32'h0,        0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    tbl[7] = mk(0, 5, 0, 1, 0, 1, 1, 5, 0, 32'h77, 32'h0,        0, 0, 32'h0,  0, 32'h0);
    tbl[8] = mk(1, 6, 5, 0, 1, 1, 1, 6, 1, 32'h66, 32'h0,        0, 0, 32'h0,  1, 32'h77);
    tbl[9] = mk(1, 2, 6, 1, 1, 0, 1, 2, 1, 32'h22, 32'h3C3C,     0, 0, 32'h0,  1, 32'h3C3C);

    // ---- reset state ----
    idle();
    #12;
    chk("rst_forward_rs", 32'(forward_rs), 32'h0);
    chk("rst_forward_rs_data", forward_rs_data, 32'h0);
    chk("rst_forward_rt", 32'(forward_rt), 32'h0);
    chk("rst_forward_rt_data", forward_rt_data, 32'h0);
    chk("rst_stall_id", 32'(stall_id), 32'h0);
    chk("rst_bubble_ex", 32'(bubble_ex), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ---- vector table ----
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_id(tbl[i].idv, tbl[i].rs, tbl[i].rt, tbl[i].rsu, tbl[i].rtu, 1'b0);
      set_ex(tbl[i].exv, tbl[i].exw, tbl[i].exr, tbl[i].exl, tbl[i].res, 1'b0);
      mem_load_data = tbl[i].mld;
      #1;
      chk($sformatf("vec%0d_stall_id", i), 32'(stall_id), 32'(tbl[i].stall));
      chk($sformatf("vec%0d_bubble_ex", i), 32'(bubble_ex), 32'(tbl[i].stall));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_forward_rs", i), 32'(forward_rs), 32'(tbl[i].frs));
      chk($sformatf("vec%0d_forward_rs_data", i), forward_rs_data, tbl[i].frsd);
      chk($sformatf("vec%0d_forward_rt", i), 32'(forward_rt), 32'(tbl[i].frt));
      chk($sformatf("vec%0d_forward_rt_data", i), forward_rt_data, tbl[i].frtd);
    end

    // ---- div then mfhi: exactly DIVC-1 stall cycles ----
    do_reset();
    set_ex(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    set_ex(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    scount = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!stall_id) break;
      scount++;
      @(negedge clk);
    end
    chk("div_stall_cycles", 32'(scount), 32'(DIVC - 1));
    chk("div_released_stall", 32'(stall_id), 32'h0);
    chk("div_released_bubble", 32'(bubble_ex), 32'h0);

    // ---- load-use under freeze ----
    do_reset();
    freeze = 1'b1;
    set_ex(1'b1, 1'b1, 5'd5, 1'b1, 32'h99, 1'b0);
    set_id(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      mem_load_data = $urandom;
      #1;
      chk($sformatf("frz%0d_stall_id", k), 32'(stall_id), 32'h0);
      chk($sformatf("frz%0d_bubble_ex", k), 32'(bubble_ex), 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("frz%0d_forward_rt", k), 32'(forward_rt), 32'h0);
      @(negedge clk);
    end
    freeze = 1'b0;
    #1;
    chk("frz_release_stall", 32'(stall_id), 32'h1);
    @(negedge clk);
    set_ex(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
    freeze = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mem_load_data = 32'h5555_0000 + 32'(k);
      @(posedge clk);
      #1;
      chk($sformatf("frz_mem%0d_forward_rt", k), 32'(forward_rt), 32'h0);
      @(negedge clk);
    end
    freeze = 1'b0;
    mem_load_data = 32'hCAFEF00D;
    #1;
    chk("frz_resolve_stall", 32'(stall_id), 32'h0);
    @(posedge clk);
    #1;
    chk("frz_resolve_forward_rt", 32'(forward_rt), 32'h1);
    chk("frz_resolve_forward_rt_data", forward_rt_data, 32'hCAFEF00D);

    // ---- reset asserted mid-divide ----
    do_reset();
    set_ex(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 21; k++) begin
      if (k == 20) set_ex(1'b1, 1'b1, 5'd3, 1'b0, 32'h11, 1'b0);
      else         set_ex(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
    end
    set_ex(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("middiv_pre_forward_rs", 32'(forward_rs), 32'h1);
    chk("middiv_pre_forward_rs_data", forward_rs_data, 32'h11);
    chk("middiv_pre_stall", 32'(stall_id), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("middiv_rst_stall", 32'(stall_id), 32'h0);
    chk("middiv_rst_bubble", 32'(bubble_ex), 32'h0);
    chk("middiv_rst_forward_rs", 32'(forward_rs), 32'h0);
    chk("middiv_rst_forward_rs_data", forward_rs_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("middiv_after_stall", 32'(stall_id), 32'h0);
    @(posedge clk);
    #1;
    chk("middiv_after_forward_rs", 32'(forward_rs), 32'h0);

    // ---- randomized run against the model ----
    do_reset();
    inflight.delete();
    nf_edges = 0;
    div_mark = -1000;
    e_frs = 0; e_frt = 0; e_frsd = 0; e_frtd = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      freeze        = ($urandom_range(0, 9) == 0);
      id_valid      = ($urandom_range(0, 4) != 0);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      id_rs_used    = 1'($urandom_range(0, 1));
      id_rt_used    = 1'($urandom_range(0, 1));
      id_hilo_used  = ($urandom_range(0, 2) == 0);
      ex_valid      = 1'($urandom_range(0, 1));
      ex_wen        = ($urandom_range(0, 3) != 0);
      ex_wreg       = 5'($urandom_range(0, 3));
      ex_is_load    = ($urandom_range(0, 3) == 0);
      ex_div_start  = ($urandom_range(0, 39) == 0);
      ex_result     = $urandom;
      mem_load_data = $urandom;
      #1;
      lookup(id_rs_used, id_rs, hs, ds, ls);
      lookup(id_rt_used, id_rt, ht, dt, lt);
      busy    = (nf_edges - div_mark) < (DIVC - 1);
      e_stall = !freeze && id_valid && (ls || lt || (id_hilo_used && busy));
      chk("rnd_stall_id", 32'(stall_id), 32'(e_stall));
      chk("rnd_bubble_ex", 32'(bubble_ex), 32'(e_stall));
      if (!freeze) begin
        if (!id_valid || ls || lt) begin
          e_frs = 0; e_frsd = 0; e_frt = 0; e_frtd = 0;
        end else begin
          e_frs = hs; e_frsd = ds; e_frt = ht; e_frtd = dt;
        end
      end
      @(posedge clk);
      if (!freeze) model_edge();
      #1;
      chk("rnd_forward_rs", 32'(forward_rs), 32'(e_frs));
      chk("rnd_forward_rs_data", forward_rs_data, e_frsd);
      chk("rnd_forward_rt", 32'(forward_rt), 32'(e_frt));
      chk("rnd_forward_rt_data", forward_rt_data, e_frtd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
